// File: rtl/hazard_pkg.sv
// Shared state encoding for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE   = 2'd0,
    HZ_LSTALL = 2'd1,
    HZ_MWAIT  = 2'd2,
    HZ_FLUSH  = 2'd3
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_timer.sv
// Multiply/divide busy timer: busy for MDU_LATENCY-1 cycles after mdu_start.
// A restart while busy reloads; a start killed by a flush is dropped.
module mdu_busy_timer #(
  parameter int MDU_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic mdu_start,
  input  logic kill,
  output logic mdu_busy
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (mdu_start && !kill) begin
      cnt <= 8'(MDU_LATENCY - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign mdu_busy = (cnt != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline; outputs are same-cycle, flush beats stall.
// HAZARD_FORWARDING_EN selects forwarding rules; without it EX/MEM producers also stall.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LOAD_STALL  = 1,
  parameter int MDU_LATENCY = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_use_rs,
  input  logic              if_id_use_rt,
  input  logic              if_id_use_hilo,
  input  logic              id_ex_memread,
  input  logic              id_ex_regwrite,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              mdu_start,
  input  logic              branch_confirm,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic              mdu_busy,
  output logic [1:0]        hz_state
);

  localparam logic [2:0] LOAD_CNT = 3'(LOAD_STALL - 1);

  hz_state_t  state;
  logic [2:0] lcnt;
  logic       load_hz;
  logic       raw_hz;
  logic       mdu_hz;
  logic       stall;

  // Register 0 is hardwired, so a zero destination can never match.
  function automatic logic src_hit(input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rt,
                                   input logic              use_rs,
                                   input logic              use_rt);
    return (rd != '0) && ((use_rs && rs == rd) || (use_rt && rt == rd));
  endfunction

  assign load_hz = id_ex_memread && id_ex_regwrite &&
                   src_hit(id_ex_rd, if_id_rs, if_id_rt, if_id_use_rs, if_id_use_rt);

`ifdef HAZARD_FORWARDING_EN
  assign raw_hz = 1'b0;
`else
  assign raw_hz = (id_ex_regwrite &&
                   src_hit(id_ex_rd, if_id_rs, if_id_rt, if_id_use_rs, if_id_use_rt)) ||
                  (ex_mem_regwrite &&
                   src_hit(ex_mem_rd, if_id_rs, if_id_rt, if_id_use_rs, if_id_use_rt));
`endif

  assign mdu_hz = if_id_use_hilo && mdu_busy;

  mdu_busy_timer #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_timer (
    .clk      (clk),
    .rst      (rst),
    .mdu_start(mdu_start),
    .kill     (branch_confirm),
    .mdu_busy (mdu_busy)
  );

  always_comb begin
    stall        = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (branch_confirm) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (state == HZ_LSTALL || mdu_hz || load_hz || raw_hz) begin
      stall        = 1'b1;
      bubble_id_ex = 1'b1;
    end
  end

  assign stall_pc    = stall;
  assign stall_if_id = stall;
  assign hz_state    = state;

  // A committed load stall runs out its counter; only a branch can cut it short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HZ_IDLE;
      lcnt  <= '0;
    end else if (branch_confirm) begin
      state <= HZ_FLUSH;
      lcnt  <= '0;
    end else if (state == HZ_LSTALL) begin
      if (lcnt == 3'd1) begin
        state <= HZ_IDLE;
        lcnt  <= '0;
      end else begin
        lcnt <= lcnt - 3'd1;
      end
    end else if (mdu_hz) begin
      state <= HZ_MWAIT;
    end else if (load_hz && LOAD_STALL > 1) begin
      state <= HZ_LSTALL;
      lcnt  <= LOAD_CNT;
    end else begin
      state <= HZ_IDLE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: two controllers (load depth 3 and 1, MDU latency 4) share one stimulus stream.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
  logic       if_id_use_rs, if_id_use_rt, if_id_use_hilo;
  logic       id_ex_memread, id_ex_regwrite, ex_mem_regwrite;
  logic       mdu_start, branch_confirm;

  logic       spc3, sif3, bub3, fl3, busy3;
  logic [1:0] st3;
  logic       spc1, sif1, bub1, fl1, busy1;
  logic [1:0] st1;
  logic [3:0] v3, v1;

  int n_cmp = 0;
  int n_err = 0;

`ifdef HAZARD_FORWARDING_EN
  localparam logic [3:0] RAW_EXP = 4'b0000;
`else
  localparam logic [3:0] RAW_EXP = 4'b1110;
`endif

  assign v3 = {spc3, sif3, bub3, fl3};
  assign v1 = {spc1, sif1, bub1, fl1};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .MDU_LATENCY(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
    .if_id_use_hilo(if_id_use_hilo),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mdu_start(mdu_start), .branch_confirm(branch_confirm),
    .stall_pc(spc3), .stall_if_id(sif3), .bubble_id_ex(bub3), .flush_if_id(fl3),
    .mdu_busy(busy3), .hz_state(st3)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .MDU_LATENCY(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
    .if_id_use_hilo(if_id_use_hilo),
    .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite), .id_ex_rd(id_ex_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mdu_start(mdu_start), .branch_confirm(branch_confirm),
    .stall_pc(spc1), .stall_if_id(sif1), .bubble_id_ex(bub1), .flush_if_id(fl1),
    .mdu_busy(busy1), .hz_state(st1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start of a new cycle: inputs change on the falling edge, all quiet by default.
  task automatic cyc();
    @(negedge clk);
    if_id_rs = '0; if_id_rt = '0; id_ex_rd = '0; ex_mem_rd = '0;
    if_id_use_rs = 1'b0; if_id_use_rt = 1'b0; if_id_use_hilo = 1'b0;
    id_ex_memread = 1'b0; id_ex_regwrite = 1'b0; ex_mem_regwrite = 1'b0;
    mdu_start = 1'b0; branch_confirm = 1'b0;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_rd = rd;
  endtask

  initial begin
    #1 rst = 1'b1;
    cyc(); #1;
    chk("reset_outs3", v3, 4'b0000);
    chk("reset_outs1", v1, 4'b0000);
    chk("reset_state", st3, 2'd0);
    chk("reset_busy", busy3, 1'b0);
    @(negedge clk); rst = 1'b0;

    // lw $8 in EX, consumer reads $8 through rs
    cyc(); load_in_ex(5'd8); if_id_rs = 5'd8; if_id_use_rs = 1'b1; #1;
    chk("lu_rs_c1_d3", v3, 4'b1110);
    chk("lu_rs_c1_d1", v1, 4'b1110);
    chk("lu_rs_c1_st", st3, 2'd0);
    cyc(); if_id_rs = 5'd8; if_id_use_rs = 1'b1; #1;
    chk("lu_rs_c2_d3", v3, 4'b1110);
    chk("lu_rs_c2_st", st3, 2'd1);
    chk("lu_rs_c2_d1", v1, 4'b0000);
    chk("lu_rs_c2_st1", st1, 2'd0);
    cyc(); if_id_rs = 5'd8; if_id_use_rs = 1'b1; #1;
    chk("lu_rs_c3_d3", v3, 4'b1110);
    chk("lu_rs_c3_st", st3, 2'd1);
    cyc(); if_id_rs = 5'd8; if_id_use_rs = 1'b1; #1;
    chk("lu_rs_c4_d3", v3, 4'b0000);
    chk("lu_rs_c4_st", st3, 2'd0);

    // lw $9, consumer reads $9 through rt
    cyc(); load_in_ex(5'd9); if_id_rt = 5'd9; if_id_use_rt = 1'b1; #1;
    chk("lu_rt_d3", v3, 4'b1110);
    chk("lu_rt_d1", v1, 4'b1110);
    cyc(); #1; chk("lu_rt_c2_st", st3, 2'd1);
    cyc(); #1; chk("lu_rt_c3_st", st3, 2'd1);
    cyc(); #1; chk("lu_rt_c4_d3", v3, 4'b0000);

    // register 0 and unused operands never hazard
    cyc(); load_in_ex(5'd0); if_id_rs = 5'd0; if_id_use_rs = 1'b1; #1;
    chk("lw_r0", v3, 4'b0000);
    cyc(); load_in_ex(5'd9); if_id_rt = 5'd9; if_id_use_rt = 1'b0; #1;
    chk("rt_unused_d3", v3, 4'b0000);
    chk("rt_unused_d1", v1, 4'b0000);

    // mult then mfhi: three stall cycles, then mfhi proceeds
    cyc(); mdu_start = 1'b1; #1;
    chk("mdu_start_busy", busy3, 1'b0);
    chk("mdu_start_outs", v3, 4'b0000);
    cyc(); if_id_use_hilo = 1'b1; #1;
    chk("mdu_c1_busy", busy3, 1'b1);
    chk("mdu_c1_outs", v3, 4'b1110);
    cyc(); if_id_use_hilo = 1'b1; #1;
    chk("mdu_c2_st", st3, 2'd2);
    chk("mdu_c2_outs", v3, 4'b1110);
    cyc(); if_id_use_hilo = 1'b1; #1;
    chk("mdu_c3_outs", v3, 4'b1110);
    chk("mdu_c3_busy", busy3, 1'b1);
    cyc(); if_id_use_hilo = 1'b1; #1;
    chk("mdu_c4_busy", busy3, 1'b0);
    chk("mdu_c4_outs", v3, 4'b0000);
    cyc(); #1; chk("mdu_c5_st", st3, 2'd0);

    // branch during LSTALL (counter=2) abandons the stall; killed mdu_start ignored
    cyc(); load_in_ex(5'd5); if_id_rs = 5'd5; if_id_use_rs = 1'b1; #1;
    chk("br_ls_setup", v3, 4'b1110);
    cyc(); branch_confirm = 1'b1; mdu_start = 1'b1; #1;
    chk("br_ls_outs", v3, 4'b0011);
    chk("br_ls_st", st3, 2'd1);
    cyc(); #1;
    chk("br_flush_st", st3, 2'd3);
    chk("br_flush_outs", v3, 4'b0000);
    chk("br_kill_mdu", busy3, 1'b0);
    cyc(); #1; chk("br_back_idle", st3, 2'd0);

    // branch and load hazard together: flush only
    cyc(); branch_confirm = 1'b1; load_in_ex(5'd7); if_id_rt = 5'd7; if_id_use_rt = 1'b1; #1;
    chk("br_lu_d3", v3, 4'b0011);
    chk("br_lu_d1", v1, 4'b0011);
    cyc(); #1; chk("br_lu_st", st3, 2'd3);

    // ALU producer $3: EX then MEM stage
    cyc(); id_ex_regwrite = 1'b1; id_ex_rd = 5'd3; if_id_rs = 5'd3; if_id_use_rs = 1'b1; #1;
    chk("raw_ex", v3, RAW_EXP);
    cyc(); ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd3; if_id_rs = 5'd3; if_id_use_rs = 1'b1; #1;
    chk("raw_mem", v3, RAW_EXP);
    chk("raw_mem_st", st3, 2'd0);
    cyc(); if_id_rs = 5'd3; if_id_use_rs = 1'b1; #1;
    chk("raw_done", v3, 4'b0000);

    // asynchronous reset in the middle of a load stall and MDU run
    cyc(); load_in_ex(5'd6); if_id_rs = 5'd6; if_id_use_rs = 1'b1; mdu_start = 1'b1; #1;
    chk("rst_setup", v3, 4'b1110);
    cyc(); load_in_ex(5'd6); if_id_rs = 5'd6; if_id_use_rs = 1'b1; #1;
    chk("rst_pre_st", st3, 2'd1);
    chk("rst_pre_busy", busy3, 1'b1);
    rst = 1'b1; #1;
    chk("rst_mid_d3", v3, 4'b0000);
    chk("rst_mid_d1", v1, 4'b0000);
    chk("rst_mid_st", st3, 2'd0);
    chk("rst_mid_busy", busy3, 1'b0);
    cyc(); rst = 1'b0; #1;
    chk("rst_after_st", st3, 2'd0);
    chk("rst_after_outs", v3, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
